// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage sequencer: walks butterflies stage by stage, issues
// operand/twiddle addresses to the butterfly core, counts completions and
// flips the ping-pong bank between stages.
module fft_stage_sequencer #(
   parameter int FFT_N = 10,
   localparam int SW = (FFT_N < 2) ? 1 : $clog2(FFT_N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               hold,
   input  logic               bt_oact,
   output logic               iact,
   output logic [1:0]         ictrl,
   output logic [FFT_N-2:0]   bfly_idx,
   output logic [FFT_N-1:0]   rd_addr_a,
   output logic [FFT_N-1:0]   rd_addr_b,
   output logic [FFT_N-2:0]   twiddle_addr,
   output logic [SW-1:0]      stage,
   output logic               bank,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int JW = FFT_N - 1;
   localparam int CW = FFT_N;
   localparam logic [JW-1:0]    J_LAST = '1;
   localparam logic [JW-1:0]    J_ONE  = JW'(1);
   localparam logic [SW-1:0]    S_LAST = SW'(FFT_N - 1);
   localparam logic [SW-1:0]    S_ONE  = SW'(1);
   localparam logic [CW-1:0]    C_ONE  = CW'(1);
   localparam logic [CW-1:0]    C_HALF = C_ONE << (FFT_N - 1);
   localparam logic [FFT_N-1:0] A_ONE  = FFT_N'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [JW-1:0]    j_q, j_d;
   logic [SW-1:0]    s_q, s_d;
   logic             bank_q, bank_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             iact_q, iact_d;
   logic [1:0]       ictrl_q, ictrl_d;
   logic [JW-1:0]    idx_q, idx_d;
   logic [FFT_N-1:0] addr_a_q, addr_a_d;
   logic [FFT_N-1:0] addr_b_q, addr_b_d;
   logic [JW-1:0]    tw_q, tw_d;

   logic             cnt_full, cnt_reach, stage_last;
   logic [CW-1:0]    cnt_sat;
   logic [JW-1:0]    mask_j, pos, hi;
   logic [FFT_N-1:0] h, addr_a_n;
   logic [SW-1:0]    tw_sh;

   // Completion count including this cycle's pulse, saturating at N/2.
   assign cnt_full   = (cnt_q == C_HALF);
   assign cnt_sat    = (bt_oact && !cnt_full) ? cnt_q + C_ONE : cnt_q;
   assign cnt_reach  = (cnt_sat == C_HALF);
   assign stage_last = (s_q == S_LAST);

   // Operand A inserts a zero bit at position s of j; mask_j wraps to all-ones
   // on the final stage because J_ONE << s overflows to zero.
   assign mask_j   = (J_ONE << s_q) - J_ONE;
   assign pos      = j_q & mask_j;
   assign hi       = j_q & ~mask_j;
   assign addr_a_n = {hi, 1'b0} | {1'b0, pos};
   assign h        = A_ONE << s_q;
   assign tw_sh    = S_LAST - s_q;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         j_q      <= '0;
         s_q      <= '0;
         bank_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         iact_q   <= 1'b0;
         ictrl_q  <= '0;
         idx_q    <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         tw_q     <= '0;
      end else begin
         state_q  <= state_d;
         j_q      <= j_d;
         s_q      <= s_d;
         bank_q   <= bank_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         iact_q   <= iact_d;
         ictrl_q  <= ictrl_d;
         idx_q    <= idx_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         tw_q     <= tw_d;
      end
   end

   // Next-state selection for the issue/drain sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (!hold && (j_q == J_LAST)) state_d = DRAIN;
         DRAIN:   if (cnt_reach) state_d = stage_last ? DONE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state outputs, butterfly issue, completion counting and error capture.
   always_comb begin
      j_d      = j_q;
      s_d      = s_q;
      bank_d   = bank_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      iact_d   = 1'b0;
      ictrl_d  = ictrl_q;
      idx_d    = idx_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      tw_d     = tw_q;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bt_oact) err_d = 1'b1;
            if (start) begin
               j_d    = '0;
               s_d    = '0;
               bank_d = 1'b0;
               cnt_d  = '0;
            end
         end
         ISSUE: begin
            busy  = 1'b1;
            cnt_d = cnt_sat;
            if (bt_oact && cnt_full) err_d = 1'b1;
            if (!hold) begin
               iact_d   = 1'b1;
               ictrl_d  = {stage_last, (j_q == '0)};
               idx_d    = j_q;
               addr_a_d = addr_a_n;
               addr_b_d = addr_a_n + h;
               tw_d     = pos << tw_sh;
               j_d      = j_q + J_ONE;
            end
         end
         DRAIN: begin
            busy  = 1'b1;
            cnt_d = cnt_sat;
            if (bt_oact && cnt_full) err_d = 1'b1;
            if (cnt_reach && !stage_last) begin
               s_d    = s_q + S_ONE;
               bank_d = ~bank_q;
               cnt_d  = '0;
            end
         end
         DONE: begin
            done = 1'b1;
            if (bt_oact) err_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign iact         = iact_q;
   assign ictrl        = ictrl_q;
   assign bfly_idx     = idx_q;
   assign rd_addr_a    = addr_a_q;
   assign rd_addr_b    = addr_b_q;
   assign twiddle_addr = tw_q;
   assign stage        = s_q;
   assign bank         = bank_q;
   assign err          = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at FFT_N=3 (8 points).
module tb_fft_stage_sequencer;

   localparam int FFT_N = 3;
   localparam int HALF  = 1 << (FFT_N - 1);
   localparam int SW    = (FFT_N < 2) ? 1 : $clog2(FFT_N);

   logic             clk, reset, start, hold, bt_oact;
   logic             iact;
   logic [1:0]       ictrl;
   logic [FFT_N-2:0] bfly_idx;
   logic [FFT_N-1:0] rd_addr_a, rd_addr_b;
   logic [FFT_N-2:0] twiddle_addr;
   logic [SW-1:0]    stage;
   logic             bank, busy, done, err;

   int checks = 0;
   int errors = 0;
   int err_exp = 0;
   int use_tab = 0;

   int tab_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int tab_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int tab_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   fft_stage_sequencer #(.FFT_N(FFT_N)) dut (
      .clk(clk), .reset(reset), .start(start), .hold(hold), .bt_oact(bt_oact),
      .iact(iact), .ictrl(ictrl), .bfly_idx(bfly_idx),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .twiddle_addr(twiddle_addr),
      .stage(stage), .bank(bank), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Butterfly geometry from plain arithmetic: groups of h pairs spaced 2h apart.
   task automatic model(input int s, input int j, output int a, output int b,
                        output int tw, output int ic);
      int h;
      h  = 1 << s;
      a  = (j / h) * 2 * h + (j % h);
      b  = a + h;
      tw = (j % h) * (HALF / h);
      ic = ((s == FFT_N - 1) ? 2 : 0) + ((j == 0) ? 1 : 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_iact"}, iact, 0);
      check({tag, "_ictrl"}, ictrl, 0);
      check({tag, "_idx"}, bfly_idx, 0);
      check({tag, "_a"}, rd_addr_a, 0);
      check({tag, "_b"}, rd_addr_b, 0);
      check({tag, "_tw"}, twiddle_addr, 0);
      check({tag, "_stage"}, stage, 0);
      check({tag, "_bank"}, bank, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // mode 0: no hold; 1: random hold/start; 2: three-cycle hold at j=2 of stage 0.
   task automatic run_stage(input int s, input int mode, input int limit);
      int k = 0, sent = 0, held = 0, guard = 0;
      int a, b, tw, ic;
      logic exp_iact;
      while (sent < limit || k < HALF) begin
         if (guard++ > 300) begin
            checks++;
            errors++;
            $error("FAIL stage_timeout observed=stuck expected=progress");
            return;
         end
         hold = 1'b0;
         bt_oact = 1'b0;
         start = 1'b0;
         if (mode == 1) begin
            hold  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 3) == 0);
         end
         if (mode == 2 && s == 0 && k == 2 && held < 3) begin
            hold = 1'b1;
            held++;
         end
         if (sent < limit && sent < k) bt_oact = ($urandom_range(0, 1) == 1);
         exp_iact = (k < HALF) && !hold;
         tick();
         if (bt_oact) sent++;
         check("iact", iact, exp_iact);
         if (exp_iact) begin
            model(s, k, a, b, tw, ic);
            check("bfly_idx", bfly_idx, k);
            check("rd_addr_a", rd_addr_a, a);
            check("rd_addr_b", rd_addr_b, b);
            check("twiddle", twiddle_addr, tw);
            check("ictrl", ictrl, ic);
            if (use_tab != 0) begin
               check("tab_a", rd_addr_a, tab_a[s*4+k]);
               check("tab_b", rd_addr_b, tab_b[s*4+k]);
               check("tab_tw", twiddle_addr, tab_t[s*4+k]);
            end
            k++;
         end
         if (!(s == FFT_N - 1 && sent == HALF)) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
         end
         if (sent < HALF) begin
            check("stage_run", stage, s);
            check("bank_run", bank, s % 2);
         end
      end
      hold = 1'b0;
      bt_oact = 1'b0;
      start = 1'b0;
      if (limit == HALF) begin
         check("iact_after_drain", iact, 0);
         if (s < FFT_N - 1) begin
            check("stage_next", stage, s + 1);
            check("bank_next", bank, (s + 1) % 2);
            check("busy_next", busy, 1);
            check("done_next", done, 0);
         end else begin
            check("done_pulse", done, 1);
            check("busy_done", busy, 0);
            check("bank_final", bank, (FFT_N - 1) % 2);
            tick();
            check("done_clear", done, 0);
            check("busy_idle", busy, 0);
         end
      end
   endtask

   task automatic run_transform(input int mode);
      start = 1'b1;
      hold = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_stage", stage, 0);
      check("start_bank", bank, 0);
      check("start_iact", iact, 0);
      for (int s = 0; s < FFT_N; s++) run_stage(s, mode, HALF);
      check("err_transform", err, err_exp);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      hold = 1'b0;
      bt_oact = 1'b0;
      tick();
      tick();
      check_reset("por");
      reset = 1'b1;

      use_tab = 1;
      run_transform(0);
      use_tab = 0;
      run_transform(2);
      repeat (3) run_transform(1);

      // Abort mid stage 1, with a completion pulse racing the reset edge.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_stage(0, 0, HALF);
      tick();
      tick();
      check("pre_reset_stage", stage, 1);
      reset = 1'b0;
      bt_oact = 1'b1;
      tick();
      reset = 1'b1;
      bt_oact = 1'b0;
      check_reset("midreset");

      bt_oact = 1'b1;
      tick();
      bt_oact = 1'b0;
      err_exp = 1;
      check("err_idle_oact", err, 1);
      tick();
      check("err_sticky", err, 1);
      run_transform(1);

      reset = 1'b0;
      tick();
      reset = 1'b1;
      err_exp = 0;
      check("err_cleared", err, 0);

      // Final stage starved of one completion must wait in drain.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_stage(0, 1, HALF);
      run_stage(1, 1, HALF);
      run_stage(2, 1, HALF - 1);
      repeat (5) begin
         tick();
         check("stall_busy", busy, 1);
         check("stall_done", done, 0);
         check("stall_stage", stage, FFT_N - 1);
         check("stall_iact", iact, 0);
         check("stall_err", err, 0);
      end
      bt_oact = 1'b1;
      tick();
      check("late_done", done, 1);
      check("late_busy", busy, 0);
      check("late_bank", bank, 0);
      check("late_err", err, 0);
      tick();
      bt_oact = 1'b0;
      check("extra_oact_err", err, 1);
      check("extra_done_clear", done, 0);
      check("extra_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter FFT_N, default 10, meaning log2 of transform length (N = 2^FFT_N points, N/2 butterflies per stage).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin a transform; sampled only in IDLE.
REQ-005 SHALL have port hold, input, 1 bit: suppress issue this cycle (upstream RAM not ready).
REQ-006 SHALL have port bt_oact, input, 1 bit: butterfly core output-active, one pulse per completed butterfly.
REQ-007 SHALL have port iact, output, 1 bit: butterfly issue strobe to core.
REQ-008 SHALL have port ictrl, output, 2 bits: [0] = first butterfly of stage, [1] = final stage.
REQ-009 SHALL have port bfly_idx, output, FFT_N-1 bits: butterfly index j, driven to core input_memory_address.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b, output, FFT_N bits each: RAM read addresses of operands A and B.
REQ-011 SHALL have port twiddle_addr, output, FFT_N-1 bits: twiddle ROM index.
REQ-012 SHALL have port stage, output, ceil(log2(FFT_N)) bits (minimum 1): current stage s.
REQ-013 SHALL have port bank, output, 1 bit: ping-pong read bank; write bank is ~bank.
REQ-014 SHALL have ports busy, done and err, output, 1 bit each: transform in progress; one-cycle completion pulse; sticky protocol error.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL go to ISSUE with s=0, j=0, bank=0, completion count=0; start in any other state SHALL be ignored.
REQ-017 ISSUE: each cycle with hold=0 SHALL register one butterfly (iact=1 plus all of REQ-018..REQ-020 next cycle) and increment j; hold=1 SHALL drive iact=0 and freeze j.
REQ-018 Addresses, with h = 2^s and pos = j mod h: rd_addr_a = ((j>>s)<<(s+1)) | pos; rd_addr_b = rd_addr_a + h.
REQ-019 twiddle_addr SHALL be pos << (FFT_N-1-s), truncated to FFT_N-1 bits.
REQ-020 ictrl[0] SHALL be 1 only when j=0; ictrl[1] SHALL be 1 only when s=FFT_N-1; all address/ctrl outputs SHALL be registered and aligned with iact.
REQ-021 Issuing j=N/2-1 SHALL go to DRAIN; j SHALL wrap to 0.
REQ-022 A completion counter (FFT_N bits) SHALL increment on every bt_oact in ISSUE or DRAIN, including oact arriving before DRAIN.
REQ-023 DRAIN: when count = N/2 (count including the current cycle's bt_oact), if s = FFT_N-1 SHALL go to DONE, otherwise s += 1, bank toggles, count=0 and ISSUE resumes on the next cycle.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE; bank is left at its final value until the next start.
REQ-025 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-026 bt_oact in IDLE or DONE, or bt_oact when count already equals N/2, SHALL set err; err clears only on reset; the counter SHALL saturate at N/2.
REQ-027 Outputs other than those listed SHALL hold their last value when iact=0; hold SHALL have no effect in DRAIN.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, j=0, s=0, bank=0, count=0, iact=0, ictrl=0, bfly_idx=0, rd_addr_a=0, rd_addr_b=0, twiddle_addr=0, busy=0, done=0 and err=0, including mid-transform; in-flight bt_oact pulses after reset release in IDLE SHALL set err.

Verification (FFT_N=3, N=8)
REQ-029 Stage 0: start, no hold -> four iact cycles, (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0); ictrl = 01,00,00,00.
REQ-030 Stage 1 after 4 oacts -> bank=1; (a,b,tw) = (0,2,0), (1,3,2), (4,6,0), (5,7,2).
REQ-031 Stage 2 -> (a,b,tw) = (0,4,0), (1,5,1), (2,6,2), (3,7,3); ictrl[1]=1; after 4th oact, done for 1 cycle, busy=0, bank=0.
REQ-032 hold=1 for 3 cycles at j=2 of stage 0 -> iact=0 for 3 cycles; sequence resumes at (4,5,0) without loss or duplication.
REQ-033 Only 3 oacts for a stage -> stays in DRAIN indefinitely; 4th oact -> advances; an extra 5th oact -> err=1.
REQ-034 reset=0 during stage 1 -> next cycle all outputs at reset values; new start runs full transform correctly.
